// File: rtl/baggage_drop_ctrl.sv
// Baggage drop sequencer: latches four height readings, derives a drop time,
// asks the decision stage for a verdict, then opens the gate or holds a reject.
module baggage_drop_ctrl #(
    parameter int unsigned T_SCALE     = 16,
    parameter int unsigned HOLD_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  sensor1,
    input  logic [7:0]  sensor2,
    input  logic [7:0]  sensor3,
    input  logic [7:0]  sensor4,
    input  logic        drop_activated,
    output logic [15:0] t_act,
    output logic        drop_en,
    output logic        gate_open,
    output logic        busy,
    output logic        done,
    output logic [1:0]  result
);

    localparam logic [15:0] TScale  = 16'(T_SCALE);
    localparam logic [15:0] HoldCnt = 16'(HOLD_CYCLES);

    localparam logic [1:0] ResNone  = 2'b00;
    localparam logic [1:0] ResDrop  = 2'b01;
    localparam logic [1:0] ResHot   = 2'b10;
    localparam logic [1:0] ResNoBag = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StCalc,
        StCheck,
        StOpen,
        StReject,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  s1_q, s1_d, s2_q, s2_d, s3_q, s3_d, s4_q, s4_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] t_act_q, t_act_d;
    logic [1:0]  result_q, result_d;
    logic        drop_en_q, drop_en_d;
    logic        gate_open_q, gate_open_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        pair_a_ok, pair_b_ok;
    logic [9:0]  sum_all;
    logic [8:0]  sum_a, sum_b;
    logic [7:0]  height;

    // Averaged height from whichever sensor pairs are fully populated.
    always_comb begin
        pair_a_ok = (s1_q != 8'd0) && (s3_q != 8'd0);
        pair_b_ok = (s2_q != 8'd0) && (s4_q != 8'd0);
        sum_all   = 10'(s1_q) + 10'(s2_q) + 10'(s3_q) + 10'(s4_q);
        sum_a     = 9'(s1_q) + 9'(s3_q);
        sum_b     = 9'(s2_q) + 9'(s4_q);
        if (pair_a_ok && pair_b_ok) begin
            height = 8'(sum_all >> 2);
        end else if (pair_b_ok) begin
            height = 8'(sum_b >> 1);
        end else begin
            height = 8'(sum_a >> 1);
        end
    end

    always_comb begin
        state_d  = state_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        s3_d     = s3_q;
        s4_d     = s4_q;
        cnt_d    = cnt_q;
        t_act_d  = t_act_q;
        result_d = result_q;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    s1_d     = sensor1;
                    s2_d     = sensor2;
                    s3_d     = sensor3;
                    s4_d     = sensor4;
                    result_d = ResNone;
                    state_d  = StCalc;
                end
            end
            StCalc: begin
                if (!pair_a_ok && !pair_b_ok) begin
                    cnt_d    = HoldCnt;
                    result_d = ResNoBag;
                    state_d  = StReject;
                end else begin
                    t_act_d = 16'(height) * TScale;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (drop_activated) begin
                    cnt_d   = t_act_q;
                    state_d = StOpen;
                end else begin
                    cnt_d    = HoldCnt;
                    result_d = ResHot;
                    state_d  = StReject;
                end
            end
            StOpen: begin
                if (cnt_q <= 16'd1) begin
                    result_d = ResDrop;
                    state_d  = StDone;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StReject: begin
                if (cnt_q <= 16'd1) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (abort && (state_q != StIdle)) begin
            state_d  = StIdle;
            result_d = ResNone;
        end

        // Registered outputs decoded from the next state; a no-bag reject keeps
        // the decision stage disabled.
        busy_d      = (state_d != StIdle);
        gate_open_d = (state_d == StOpen);
        done_d      = (state_d == StDone);
        drop_en_d   = (state_d == StCheck) || (state_d == StOpen) ||
                      ((state_d == StReject) && (result_d == ResHot));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            s1_q        <= 8'd0;
            s2_q        <= 8'd0;
            s3_q        <= 8'd0;
            s4_q        <= 8'd0;
            cnt_q       <= 16'd0;
            t_act_q     <= 16'd0;
            result_q    <= ResNone;
            drop_en_q   <= 1'b0;
            gate_open_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            s4_q        <= s4_d;
            cnt_q       <= cnt_d;
            t_act_q     <= t_act_d;
            result_q    <= result_d;
            drop_en_q   <= drop_en_d;
            gate_open_q <= gate_open_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign t_act     = t_act_q;
    assign drop_en   = drop_en_q;
    assign gate_open = gate_open_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;

endmodule

// File: tb/tb_baggage_drop_ctrl.sv
// Self-checking bench for baggage_drop_ctrl: directed scenarios plus random
// drops, each compared cycle by cycle against a timeline model.
module tb_baggage_drop_ctrl;

    localparam int unsigned TS   = 4;
    localparam int unsigned HOLD = 8;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [7:0]  sensor1, sensor2, sensor3, sensor4;
    logic        drop_activated;
    logic [15:0] t_act;
    logic        drop_en, gate_open, busy, done;
    logic [1:0]  result;
    logic [15:0] t_lim;

    int          vectors = 0;
    int          errors  = 0;
    logic [15:0] t_exp;
    logic [1:0]  res_exp;

    always #5 clk = ~clk;

    // Decision stage stand-in: allow the drop only if the time fits the limit.
    assign drop_activated = drop_en && (t_act <= t_lim);

    baggage_drop_ctrl #(
        .T_SCALE     (TS),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .sensor1        (sensor1),
        .sensor2        (sensor2),
        .sensor3        (sensor3),
        .sensor4        (sensor4),
        .drop_activated (drop_activated),
        .t_act          (t_act),
        .drop_en        (drop_en),
        .gate_open      (gate_open),
        .busy           (busy),
        .done           (done),
        .result         (result)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic chk_idle();
        chk("idle_busy", 16'(busy), 16'd0);
        chk("idle_done", 16'(done), 16'd0);
        chk("idle_gate", 16'(gate_open), 16'd0);
        chk("idle_drop_en", 16'(drop_en), 16'd0);
        chk("idle_result", 16'(result), 16'(res_exp));
        chk("idle_t_act", t_act, t_exp);
    endtask

    // Returns {valid, drop time}; valid=0 means no bag.
    function automatic logic [16:0] model_t(input int a, input int b, input int c, input int d);
        bit va, vb;
        int h;
        va = (a != 0) && (c != 0);
        vb = (b != 0) && (d != 0);
        if (va && vb)  h = (a + b + c + d) / 4;
        else if (vb)   h = (b + d) / 2;
        else if (va)   h = (a + c) / 2;
        else           return 17'd0;
        return {1'b1, 16'((h * TS) % 65536)};
    endfunction

    function automatic logic [7:0] rnd_sensor();
        if ($urandom_range(0, 3) == 0) return 8'd0;
        return 8'($urandom_range(1, 255));
    endfunction

    task automatic run_drop(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input logic [7:0] d, input logic [15:0] lim, input int abort_at,
                            input int rst_at, input bit noise, input bit keep);
        logic [16:0] m;
        bit          valid, ok;
        int          t, last;
        logic [1:0]  r_e;
        m     = model_t(int'(a), int'(b), int'(c), int'(d));
        valid = m[16];
        t     = int'(m[15:0]);
        ok    = valid && (m[15:0] <= lim);
        if (!valid)  last = 2 + HOLD;
        else if (ok) last = 3 + t;
        else         last = 3 + HOLD;

        sensor1 = a; sensor2 = b; sensor3 = c; sensor4 = d;
        t_lim = lim; start = 1'b1; abort = 1'b0;
        for (int n = 1; n <= last; n++) begin
            @(posedge clk); #1;
            if (valid && n == 2) t_exp = m[15:0];
            if (!valid)  r_e = (n >= 2) ? 2'b11 : 2'b00;
            else if (ok) r_e = (n == last) ? 2'b01 : 2'b00;
            else         r_e = (n >= 3) ? 2'b10 : 2'b00;
            chk("busy", 16'(busy), 16'd1);
            chk("done", 16'(done), 16'(n == last));
            chk("gate_open", 16'(gate_open), 16'(ok && n >= 3 && n < last));
            chk("drop_en", 16'(drop_en), 16'(valid && n >= 2 && n < last));
            chk("result", 16'(result), 16'(r_e));
            chk("t_act", t_act, t_exp);
            res_exp = r_e;

            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) begin
                sensor1 = 8'($urandom); sensor2 = 8'($urandom);
                sensor3 = 8'($urandom); sensor4 = 8'($urandom);
                if (n >= 3) t_lim = 16'($urandom_range(0, 1100));
            end
            if (n == abort_at) begin
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0; start = 1'b0;
                res_exp = 2'b00;
                chk_idle();
                return;
            end
            if (n == rst_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0; start = 1'b0;
                res_exp = 2'b00;
                t_exp   = 16'd0;
                chk_idle();
                return;
            end
        end
        start = keep;
        @(posedge clk); #1;
        chk_idle();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; t_lim = 16'd0;
        sensor1 = 8'd0; sensor2 = 8'd0; sensor3 = 8'd0; sensor4 = 8'd0;
        t_exp = 16'd0; res_exp = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk_idle();
        rst = 1'b0;
        @(posedge clk); #1;

        // Normal drop: h=10, t_act=40.
        run_drop(8'd10, 8'd10, 8'd10, 8'd10, 16'd100, 0, 0, 1'b0, 1'b0);
        // Hot reject: t_act=800 above limit.
        run_drop(8'd200, 8'd200, 8'd200, 8'd200, 16'd700, 0, 0, 1'b0, 1'b0);
        // Pair fallbacks: B only gives h=30; neither pair valid gives no bag.
        run_drop(8'd0, 8'd20, 8'd50, 8'd40, 16'd1000, 0, 0, 1'b0, 1'b0);
        run_drop(8'd0, 8'd0, 8'd5, 8'd5, 16'd1000, 0, 0, 1'b0, 1'b0);
        // A only.
        run_drop(8'd7, 8'd0, 8'd9, 8'd3, 16'd1000, 0, 0, 1'b0, 1'b0);
        // Abort on the fifth gate_open cycle, then reset mid-OPEN.
        run_drop(8'd10, 8'd10, 8'd10, 8'd10, 16'd100, 7, 0, 1'b0, 1'b0);
        run_drop(8'd10, 8'd10, 8'd10, 8'd10, 16'd100, 0, 10, 1'b0, 1'b0);

        // Start together with abort in IDLE stays idle.
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        chk_idle();
        start = 1'b0; abort = 1'b0;

        // Back-to-back with start held and noisy inputs during the run.
        run_drop(8'd12, 8'd14, 8'd16, 8'd18, 16'd500, 0, 0, 1'b1, 1'b1);
        run_drop(8'd30, 8'd30, 8'd30, 8'd30, 16'd500, 0, 0, 1'b1, 1'b1);

        for (int i = 0; i < 25; i++) begin
            int ab, rs;
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 12)) : 0;
            rs = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 12)) : 0;
            run_drop(rnd_sensor(), rnd_sensor(), rnd_sensor(), rnd_sensor(),
                     16'($urandom_range(0, 1100)), ab, rs, 1'b1, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
